mul_share_ctrl: RTL
===================

// Module: mul_share_ctrl
// PURPOSE
//  Sequential shift-and-add multiplier engine shared by two requesters.
//  - Round-robin arbiter grants one request at a time.
//  - FSM runs the multiply one multiplier bit per cycle, then holds the result on a valid/ready output port.
//  - Replaces the combinational unrolled multiplier where area matters more than latency.
// PARAMETERS
//  N   8   operand width in bits; product is 2*N bits
// PORTS
//  clk         in   1    single clock; all state updates on rising edge
//  rst         in   1    synchronous, active-high reset
//  req0_valid  in   1    requester 0 has operands
//  req0_ready  out  1    requester 0 granted and engine idle (combinational)
//  req0_a      in   N    requester 0 multiplicand, unsigned
//  req0_b      in   N    requester 0 multiplier, unsigned
//  req1_valid  in   1    requester 1 has operands
//  req1_ready  out  1    requester 1 granted and engine idle (combinational)
//  req1_a      in   N    requester 1 multiplicand, unsigned
//  req1_b      in   N    requester 1 multiplier, unsigned
//  res_valid   out  1    result held on res_p/res_id
//  res_ready   in   1    consumer accepts result
//  res_p       out  2N   product a*b
//  res_id      out  1    index of the requester that issued the result
//  busy        out  1    state != IDLE
// BEHAVIOUR
//  Reset:
//   - state=IDLE; res_valid=0, res_p=0, res_id=0, busy=0.
//   - Both req*_ready=0 while rst=1.
//   - RR pointer prefers req0.
//  States: IDLE, RUN, DONE.
//  IDLE:
//   - If only one req valid, grant it.
//   - If both valid, grant the one the RR pointer prefers.
//   - Only the granted requester's ready=1. Ready=0 in RUN and DONE.
//  Accept (valid&ready at edge ending cycle T):
//   - Register a zero-extended to 2N bits as mcand, and b as mplier.
//   - acc=0, cnt=0, res_id=grant.
//   - RR pointer moves to prefer the other requester.
//   - Next state is RUN.
//   - Operands are sampled only at accept and are don't-care otherwise.
//  RUN, once per cycle:
//   - If mplier[0]==1, acc += mcand.
//   - mcand <<= 1; mplier >>= 1; cnt++.
//   - After the cycle with cnt==N-1, go to DONE and load res_p=acc.
//  Latency:
//   - res_valid=1 in cycle T+N+1 (9 cycles for N=8), independent of operand values.
//  DONE:
//   - res_valid=1; res_p and res_id stay stable until res_valid&res_ready.
//   - On handshake: res_valid=0, next state IDLE.
//   - No new request is accepted in the handshake cycle. Earliest next accept is the following cycle.
//  Arithmetic:
//   - Unsigned, full 2N-bit width, never overflows.
//   - 0*x = 0; (2^N-1)^2 is exact.
//  Reset mid-operation: aborts RUN/DONE; the pending result is discarded and never signalled.
//  A requester dropping valid before grant is legal; arbitration is re-evaluated each IDLE cycle.
// CONFIGURATION
//  EARLY_TERM_EN
//   - Defined:
//     - RUN also exits to DONE when the post-shift mplier==0.
//     - At accept, b==0 goes straight to DONE with res_p=0, so res_valid appears in T+1.
//     - Latency = T + 1 + (index of highest set bit of b) + 1.
//   - Undefined: fixed N-cycle RUN as above.
//   - The arithmetic result is identical in both builds.
// TESTING
//  1. N=8, req0 a=13 b=11 only -> res_p=143, res_id=0, res_valid exactly 9 cycles after accept.
//  2. Both valid every cycle after reset (req0: 255*255, req1: 2*3) -> results 65025 id0, then 6 id1, then id0 again.
//  3. res_ready held 0 for 5 cycles in DONE -> res_valid/res_p/res_id stable, both ready=0, no accept.
//  4. rst=1 for 1 cycle mid-RUN -> res_valid never rises; req ready=1 in the first cycle rst=0 with valid high.
//  5. EARLY_TERM_EN, a=200: b=1 -> 200 at T+2; b=0 -> 0 at T+1; b=128 -> 25600 at T+9. Without the macro, all at T+9.
//  6. Random 1000 a,b pairs with random res_ready backpressure -> every res_p == a*b; res_id order matches grants.

Source files
------------

// File: rtl/mul_share_ctrl.sv
// Shift-and-add multiplier shared by two requesters through a round-robin arbiter.
// Optional EARLY_TERM_EN build ends the multiply once the remaining multiplier bits are all zero.
module mul_share_ctrl #(
    parameter int N = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           req0_valid,
    output logic           req0_ready,
    input  logic [N-1:0]   req0_a,
    input  logic [N-1:0]   req0_b,
    input  logic           req1_valid,
    output logic           req1_ready,
    input  logic [N-1:0]   req1_a,
    input  logic [N-1:0]   req1_b,
    output logic           res_valid,
    input  logic           res_ready,
    output logic [2*N-1:0] res_p,
    output logic           res_id,
    output logic           busy
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic             rr_q, rr_d;
    logic [2*N-1:0]   mcand_q, mcand_d;
    logic [N-1:0]     mplier_q, mplier_d;
    logic [2*N-1:0]   acc_q, acc_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [2*N-1:0]   res_p_q, res_p_d;
    logic             res_id_q, res_id_d;

    logic             grant;
    logic             accept;
    logic [N-1:0]     sel_a, sel_b;
    logic [2*N-1:0]   sum;
    logic             last;

    // rr_q == 0 prefers requester 0 when both are valid.
    always_comb begin
        if (req0_valid && req1_valid) grant = rr_q;
        else                          grant = req1_valid;
        accept = (state_q == IDLE) && !rst && (req0_valid || req1_valid);
        sel_a  = grant ? req1_a : req0_a;
        sel_b  = grant ? req1_b : req0_b;
    end

    // NOTE: sequential state uses <= so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            rr_q     <= 1'b0;
            res_p_q  <= '0;
            res_id_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_q     <= rr_d;
            res_p_q  <= res_p_d;
            res_id_q <= res_id_d;
        end
    end

    // NOTE: working registers are loaded at accept before use, so they carry no reset.
    always_ff @(posedge clk) begin
        mcand_q  <= mcand_d;
        mplier_q <= mplier_d;
        acc_q    <= acc_d;
        cnt_q    <= cnt_d;
    end

    // NOTE: every target gets a default first so no path infers a latch.
    always_comb begin
        state_d  = state_q;
        rr_d     = rr_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        res_p_d  = res_p_q;
        res_id_d = res_id_q;
        sum      = acc_q + (mplier_q[0] ? mcand_q : '0);
        last     = (cnt_q == CW'(N - 1));
`ifdef EARLY_TERM_EN
        last     = last || ((mplier_q >> 1) == '0);
`endif
        case (state_q)
            IDLE: begin
                if (accept) begin
                    mcand_d  = {{N{1'b0}}, sel_a};
                    mplier_d = sel_b;
                    acc_d    = '0;
                    cnt_d    = '0;
                    res_id_d = grant;
                    rr_d     = ~grant;
                    state_d  = RUN;
`ifdef EARLY_TERM_EN
                    if (sel_b == '0) begin
                        res_p_d = '0;
                        state_d = DONE;
                    end
`endif
                end
            end
            RUN: begin
                acc_d    = sum;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 1'b1;
                if (last) begin
                    res_p_d = sum;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (res_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy       = (state_q != IDLE);
        res_valid  = (state_q == DONE);
        req0_ready = accept && !grant;
        req1_ready = accept && grant;
        res_p      = res_p_q;
        res_id     = res_id_q;
    end

endmodule
